// File: rtl/uart_proto_pkg.sv
// Shared UART framing constants and the readback FSM state type.
// Imported by the memory readback FSM and any debug/LED logic that decodes its state.
package uart_proto_pkg;

  localparam int BYTE_WIDTH     = 8;
  localparam int DATA_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    RB_IDLE      = 3'd0,
    RB_SEND_CNT  = 3'd1,
    RB_WAIT_CNT  = 3'd2,
    RB_RD_REQ    = 3'd3,
    RB_RD_LATCH  = 3'd4,
    RB_SEND_BYTE = 3'd5,
    RB_WAIT_BYTE = 3'd6,
    RB_DONE      = 3'd7
  } readback_state_t;

endpackage

// File: rtl/mem_readback_fsm_word_serializer.sv
// Holds one memory word and presents it byte by byte, LSB first.
// The last flag marks the final byte of the word.
module word_serializer
  import uart_proto_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_load,
  input  logic                  i_advance,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [BYTE_WIDTH-1:0] o_byte,
  output logic                  o_last
);

  logic [DATA_WIDTH-1:0] r_word;
  logic [1:0]            r_byte_idx;

  // Word and byte-index storage; a load always restarts at byte 0
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_word     <= {DATA_WIDTH{1'b0}};
      r_byte_idx <= 2'd0;
    end else if (i_load) begin
      r_word     <= i_data;
      r_byte_idx <= 2'd0;
    end else if (i_advance) begin
      r_word     <= r_word;
      r_byte_idx <= r_byte_idx + 2'd1;
    end else begin
      r_word     <= r_word;
      r_byte_idx <= r_byte_idx;
    end
  end

  // Byte select from the stored word
  always_comb begin
    o_byte = {BYTE_WIDTH{1'b0}};
    case (r_byte_idx)
      2'd0:    o_byte = r_word[7:0];
      2'd1:    o_byte = r_word[15:8];
      2'd2:    o_byte = r_word[23:16];
      2'd3:    o_byte = r_word[31:24];
      default: o_byte = {BYTE_WIDTH{1'b0}};
    endcase
  end

  assign o_last = (r_byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_readback_fsm.sv
// Dumps N memory words to the UART TX as a count byte followed by each word LSB-first.
// Framing mirrors the UART program loader so a dump can be replayed into it.
module mem_readback_fsm #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic [BYTE_WIDTH-1:0] n_words,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  tx_start,
  output logic [BYTE_WIDTH-1:0] tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state
);

  import uart_proto_pkg::*;

  localparam logic [2:0] S_IDLE      = RB_IDLE;
  localparam logic [2:0] S_SEND_CNT  = RB_SEND_CNT;
  localparam logic [2:0] S_WAIT_CNT  = RB_WAIT_CNT;
  localparam logic [2:0] S_RD_REQ    = RB_RD_REQ;
  localparam logic [2:0] S_RD_LATCH  = RB_RD_LATCH;
  localparam logic [2:0] S_SEND_BYTE = RB_SEND_BYTE;
  localparam logic [2:0] S_WAIT_BYTE = RB_WAIT_BYTE;
  localparam logic [2:0] S_DONE      = RB_DONE;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES_PER_WORD);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [BYTE_WIDTH-1:0] r_n;
  logic [BYTE_WIDTH-1:0] r_word_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_accept;
  logic                  w_load;
  logic                  w_advance;
  logic                  w_last;
  logic                  w_last_word;
  logic                  w_next_word;
  logic [BYTE_WIDTH-1:0] w_ser_byte;

  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_load      = (r_state == S_RD_LATCH);
  assign w_advance   = (r_state == S_WAIT_BYTE) && tx_done && !w_last;
  assign w_last_word = (r_word_cnt == (r_n - 8'd1));
  assign w_next_word = (r_state == S_WAIT_BYTE) && tx_done && w_last && !w_last_word;

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      w_state_nxt = w_accept ? S_SEND_CNT : S_IDLE;
      S_SEND_CNT:  w_state_nxt = S_WAIT_CNT;
      S_WAIT_CNT: begin
        if (!tx_done) begin
          w_state_nxt = S_WAIT_CNT;
        end else if (r_n == 8'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RD_REQ;
        end
      end
      S_RD_REQ:    w_state_nxt = S_RD_LATCH;
      S_RD_LATCH:  w_state_nxt = S_SEND_BYTE;
      S_SEND_BYTE: w_state_nxt = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        if (!tx_done) begin
          w_state_nxt = S_WAIT_BYTE;
        end else if (!w_last) begin
          w_state_nxt = S_SEND_BYTE;
        end else if (w_last_word) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RD_REQ;
        end
      end
      S_DONE:      w_state_nxt = w_accept ? S_SEND_CNT : S_DONE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Word count and read address; both restart at zero on every accepted start
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_n        <= {BYTE_WIDTH{1'b0}};
      r_word_cnt <= {BYTE_WIDTH{1'b0}};
      r_addr     <= {ADDR_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_n        <= n_words;
      r_word_cnt <= {BYTE_WIDTH{1'b0}};
      r_addr     <= {ADDR_WIDTH{1'b0}};
    end else if (w_next_word) begin
      r_n        <= r_n;
      r_word_cnt <= r_word_cnt + 8'd1;
      r_addr     <= r_addr + ADDR_STEP;
    end else begin
      r_n        <= r_n;
      r_word_cnt <= r_word_cnt;
      r_addr     <= r_addr;
    end
  end

  word_serializer u_word_serializer (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_data    (rd_data),
    .o_byte    (w_ser_byte),
    .o_last    (w_last)
  );

  // Outgoing byte: count byte in the count phase, word byte in the data phase
  always_comb begin
    tx_data = {BYTE_WIDTH{1'b0}};
    case (r_state)
      S_SEND_CNT, S_WAIT_CNT:   tx_data = r_n;
      S_SEND_BYTE, S_WAIT_BYTE: tx_data = w_ser_byte;
      default:                  tx_data = {BYTE_WIDTH{1'b0}};
    endcase
  end

  assign tx_start = (r_state == S_SEND_CNT) || (r_state == S_SEND_BYTE);
  assign rd_en    = (r_state == S_RD_REQ);
  assign rd_addr  = r_addr;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done     = (r_state == S_DONE);
  assign state    = r_state;

endmodule

// File: tb/tb_mem_readback_fsm.sv
// Directed + randomized bench for mem_readback_fsm with a UART TX model, a memory model
// and an expected byte stream built straight from the dump framing rules.
module tb_mem_readback_fsm;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic [7:0]  n_words;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  mem_readback_fsm #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .start    (start),
    .n_words  (n_words),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];
  logic [7:0]  exp_q[$];
  logic [9:0]  exp_addr_q[$];
  logic [7:0]  obs_q[$];
  logic [9:0]  addr_q[$];

  // Environment state shared between the main sequence and the negedge model
  int          exp_total   = 0;
  int          stab_err    = 0;
  bit          holding     = 1'b0;
  logic [7:0]  held        = 8'h00;
  bit          inflight    = 1'b0;
  int          lat         = 0;
  bit          spurious_en = 1'b0;
  bit          rd_pend     = 1'b0;
  logic [9:0]  rd_pend_addr = 10'd0;
  bit          last_pend   = 1'b0;
  bit          done_ok     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor, memory model and UART TX model, all evaluated away from the active edge
  initial begin
    tx_done = 1'b0;
    rd_data = 32'h0;
    forever begin
      @(negedge clk);
      if (arst_n) begin
        if (holding && (tx_data !== held)) stab_err++;
        if (tx_start === 1'b1) begin
          obs_q.push_back(tx_data);
          held    = tx_data;
          holding = 1'b1;
        end
        if (rd_en === 1'b1) addr_q.push_back(rd_addr);
        if (last_pend) begin
          done_ok   = (done === 1'b1) && (busy === 1'b0);
          last_pend = 1'b0;
        end
        // Read data is only valid in the cycle after the strobe
        if (rd_pend) rd_data = mem[rd_pend_addr[9:2]];
        else         rd_data = $urandom;
        rd_pend      = (rd_en === 1'b1);
        rd_pend_addr = rd_addr;
        tx_done = 1'b0;
        if (tx_start === 1'b1) begin
          inflight = 1'b1;
          lat      = $urandom_range(1, 4);
          if (spurious_en) tx_done = 1'b1;
        end else if (inflight) begin
          lat--;
          if (lat == 0) begin
            tx_done  = 1'b1;
            inflight = 1'b0;
            holding  = 1'b0;
            if (obs_q.size() == exp_total) last_pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic build_expected(input int n);
    exp_q = {};
    exp_addr_q = {};
    exp_q.push_back(8'(n));
    for (int w = 0; w < n; w++) begin
      exp_addr_q.push_back(10'(4 * w));
      for (int b = 0; b < 4; b++) exp_q.push_back(mem[w][8*b +: 8]);
    end
    exp_total = exp_q.size();
    obs_q = {};
    addr_q = {};
    stab_err = 0;
    done_ok = 1'b0;
  endtask

  task automatic pulse_start(input int n, input string tag);
    n_words = 8'(n);
    start   = 1'b1;
    @(negedge clk); #1;
    start   = 1'b0;
    check({tag, "_startlat_txstart"}, 32'(tx_start), 32'd1);
    check({tag, "_startlat_done"},    32'(done),     32'd0);
    check({tag, "_startlat_busy"},    32'(busy),     32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    int m;
    check({tag, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_nreads"}, 32'(addr_q.size()), 32'(exp_addr_q.size()));
    m = (addr_q.size() < exp_addr_q.size()) ? addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < m; i++) check($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(exp_addr_q[i]));
    check({tag, "_txdata_stable"}, 32'(stab_err), 32'd0);
    check({tag, "_done_timing"},   32'(done_ok),  32'd1);
    check({tag, "_busy_low"},      32'(busy),     32'd0);
  endtask

  task automatic run_dump(input int n, input bit spurious, input bit busy_start, input string tag);
    build_expected(n);
    spurious_en = spurious;
    pulse_start(n, tag);
    if (busy_start) begin
      repeat (6) @(negedge clk);
      #1;
      n_words = 8'(n + 5);
      start   = 1'b1;
      @(negedge clk); #1;
      start   = 1'b0;
    end
    wait_done(tag);
    spurious_en = 1'b0;
    compare_stream(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_txstart"}, 32'(tx_start), 32'd0);
    check({tag, "_rden"},    32'(rd_en),    32'd0);
    check({tag, "_busy"},    32'(busy),     32'd0);
    check({tag, "_done"},    32'(done),     32'd0);
    check({tag, "_txdata"},  32'(tx_data),  32'd0);
    check({tag, "_rdaddr"},  32'(rd_addr),  32'd0);
    check({tag, "_state"},   32'(state),    32'd0);
  endtask

  initial begin
    bit reached;
    arst_n  = 1'b0;
    start   = 1'b0;
    n_words = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("idle");

    run_dump(0, 1'b0, 1'b0, "n0");

    mem[0] = 32'hDEADBEEF;
    run_dump(1, 1'b0, 1'b0, "n1");

    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    mem[2] = 32'h99AABBCC;
    run_dump(3, 1'b0, 1'b0, "n3");

    run_dump(3, 1'b1, 1'b1, "n3_spur");

    // Reset while byte 2 of word 1 is being launched
    build_expected(3);
    pulse_start(3, "rst");
    reached = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      if (obs_q.size() >= 8) begin
        reached = 1'b1;
        break;
      end
    end
    check("rst_reach_byte2_word1", 32'(reached), 32'd1);
    check("rst_pre_txstart", 32'(tx_start), 32'd1);
    arst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    inflight  = 1'b0;
    holding   = 1'b0;
    rd_pend   = 1'b0;
    last_pend = 1'b0;
    tx_done   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) mem[i] = $urandom;
    run_dump(2, 1'b0, 1'b0, "after_rst");

    run_dump(2, 1'b0, 1'b0, "redone");

    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) mem[i] = $urandom;
      run_dump(n, k[0], 1'b0, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_readback_fsm.md
# mem_readback_fsm

Transmit-side counterpart of the UART program loader. On a `start` request it reads N 32-bit words from a synchronous memory, starting at byte address 0, and serialises them byte-by-byte into the UART transmitter. The framing matches the loader's expected format exactly: one count byte, then each word LSB-first. It sits between the program/data memory read port and the UART TX block and is used to dump memory contents back to the host for verification.

## Interface
- `DATA_WIDTH`, 32: memory word width. Fixed at 4 bytes.
- `BYTE_WIDTH`, 8: UART byte width.
- `ADDR_WIDTH`, 10: byte address width of the memory read port.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `start` in 1: dump request; sampled only in IDLE or DONE.
- `n_words` in BYTE_WIDTH: number of words to dump; latched on accepted `start`.
- `rd_en` out 1: memory read strobe.
- `rd_addr` out ADDR_WIDTH: memory byte address, word-aligned.
- `rd_data` in DATA_WIDTH: memory read data, valid exactly 1 cycle after `rd_en`.
- `tx_start` out 1: one-cycle pulse requesting the UART to send `tx_data`.
- `tx_data` out BYTE_WIDTH: byte to send; held stable from the `tx_start` cycle until `tx_done`.
- `tx_done` in 1: one-cycle pulse from the UART TX when a byte is fully sent.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: level, high in DONE.
- `state` out 3: current state encoding, for debug.

## Operation
- All registers are asynchronously reset to zero and the state to IDLE. Out of reset every output is 0.
- Registers: `n_reg` (8b), `word_cnt` (8b), `addr` (ADDR_WIDTH), `word_reg` (32b), `byte_idx` (2b).

States and transitions:
- IDLE: on `start`, set `n_reg` = `n_words`, `addr` = 0, `word_cnt` = 0, then go to SEND_CNT.
- SEND_CNT: `tx_start` = 1, `tx_data` = `n_reg`. Go to WAIT_CNT.
- WAIT_CNT: on `tx_done`, go to DONE if `n_reg` == 0, otherwise go to RD_REQ.
- RD_REQ: `rd_en` = 1, `rd_addr` = `addr`. Go to RD_LATCH.
- RD_LATCH: `word_reg` <= `rd_data`, `byte_idx` <= 0. Go to SEND_BYTE.
- SEND_BYTE: `tx_start` = 1, `tx_data` = `word_reg[8*byte_idx +: 8]`. Go to WAIT_BYTE.
- WAIT_BYTE: on `tx_done`:
  - If `byte_idx` != 3: increment `byte_idx`, go to SEND_BYTE.
  - Else if `word_cnt` == `n_reg` − 1: go to DONE.
  - Else: `addr` += 4, `word_cnt` += 1, go to RD_REQ.
- DONE: `done` = 1. `start` restarts exactly as from IDLE, re-latching `n_words`.

Output and arithmetic rules:
- `tx_start`, `rd_en`, `busy` and `done` are decoded from the state register only (Moore).
- `tx_data` is driven from registers only and is 0 outside the SEND/WAIT states.
- `rd_addr` always equals `addr`.
- `addr` increments by 4 and wraps modulo 2^ADDR_WIDTH. With N ≤ 255 the last address is 1016, so no wrap occurs at defaults.

Boundary conditions:
- `start` outside IDLE/DONE is ignored.
- `tx_done` is ignored outside WAIT_CNT/WAIT_BYTE. This includes the SEND_* cycle itself.
- `n_words` = 0: the count byte 0x00 is sent and no memory reads occur.
- Reset asserted mid-dump returns to IDLE immediately. `tx_start` and `rd_en` drop asynchronously, and no partial word is resumed after reset.

## Timing
- `start` high in cycle 0 → `tx_start` high in cycle 1.
- `tx_done` after the count byte in cycle t → `rd_en` in t+1, `word_reg` loaded at end of t+2, `tx_start` for byte 0 in t+3.
- `tx_done` for bytes 0–2 in cycle t → `tx_start` for the next byte in t+1.
- Last `tx_done` in cycle t → `done` = 1 and `busy` = 0 from t+1.
- Each word costs 3 overhead cycles plus 4 UART byte times. Throughput is otherwise UART-bound.

## Structure
- Shared package `uart_proto_pkg`:
  - `BYTE_WIDTH` and `DATA_WIDTH` constants.
  - Bytes-per-word constant (4).
  - The `readback_state_t` 3-bit enum, shared with debug/LED logic.
- One natural sub-module, `word_serializer`: holds `word_reg`/`byte_idx`, does load/advance, and outputs the selected byte plus a last-byte flag.
- The FSM, counters and address generation stay in `mem_readback_fsm`.

## Test plan
- Reset, then `start` with `n_words` = 0 → a single `tx_start` with `tx_data` = 0x00; no `rd_en`; `done` = 1 one cycle after `tx_done`.
- `n_words` = 1, mem[0] = 0xDEADBEEF → bytes 0x01, 0xEF, 0xBE, 0xAD, 0xDE in order; exactly one `rd_en` with `rd_addr` = 0.
- `n_words` = 3, mem = {0x11223344, 0x55667788, 0x99AABBCC} → 13 bytes; `rd_addr` sequence 0, 4, 8; `tx_data` stable between each `tx_start` and `tx_done`.
- Spurious `tx_done` in SEND_BYTE, and `start` pulsed while busy → no byte skipped, no restart, output stream identical to the clean run.
- `arst_n` low during byte 2 of word 1 → all outputs 0 immediately; a new `start` with `n_words` = 2 produces the complete 9-byte stream from address 0.
- `start` again from DONE with `n_words` = 2 → second dump starts at address 0; `done` drops in the cycle after `start`.
